// File: rtl/debug_link_unit_if.sv
// UART FIFO side of the debug link: RX show-ahead pop port and TX push port.
interface debug_link_unit_if;
  logic [7:0] r_data;
  logic       rx_empty;
  logic       rd;
  logic [7:0] w_data;
  logic       tx_full;
  logic       wr;

  modport master (
    input  r_data, rx_empty, tx_full,
    output rd, w_data, wr
  );

  modport slave (
    output r_data, rx_empty, tx_full,
    input  rd, w_data, wr
  );
endinterface

// File: rtl/debug_link_unit.sv
// debug_link_unit: host command decoder driving the core enable, plus snapshot-and-stream frame dumper.
// Build macro DEBUG_LINK_CHECKSUM_EN appends an XOR checksum byte after the payload.
module debug_link_unit #(
  parameter int unsigned DBG_W  = 322,
  parameter int unsigned PC_W   = 10,
  parameter int unsigned NBYTES = 42
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [DBG_W-1:0]     debug_signal,
  input  logic [PC_W-1:0]      PC_plus_1,
  output logic                 enable,
  output logic                 busy,
  debug_link_unit_if.master    uart
);
  localparam int unsigned FRAME_W = NBYTES * 8;
  localparam int unsigned IDX_W   = $clog2(NBYTES + 1);
`ifdef DEBUG_LINK_CHECKSUM_EN
  localparam int unsigned LAST_IDX = NBYTES;
`else
  localparam int unsigned LAST_IDX = NBYTES - 1;
`endif
  localparam logic [7:0] CMD_RUN  = 8'h63;
  localparam logic [7:0] CMD_STEP = 8'h73;
  localparam logic [7:0] CMD_DUMP = 8'h64;
  localparam logic [7:0] CMD_HALT = 8'h68;

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_STEP, S_SNAP, S_SEND} state_e;

  state_e               state_q, state_d;
  logic [FRAME_W-1:0]   frame_q, frame_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 pop_c, push_c, last_c;
  logic [7:0]           tx_byte_c;

  assign pop_c  = (state_q == S_IDLE || state_q == S_RUN) && !uart.rx_empty;
  assign push_c = (state_q == S_SEND) && !uart.tx_full;
  assign last_c = (idx_q == IDX_W'(LAST_IDX));

`ifdef DEBUG_LINK_CHECKSUM_EN
  logic [7:0] csum_q, csum_d;

  // Running XOR of payload bytes; the frame register is all zero by the checksum slot
  always_comb begin
    csum_d = csum_q;
    if (state_q == S_SNAP) begin
      csum_d = '0;
    end else if (push_c) begin
      csum_d = csum_q ^ frame_q[FRAME_W-1 -: 8];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      csum_q <= '0;
    end else begin
      csum_q <= csum_d;
    end
  end

  assign tx_byte_c = (idx_q == IDX_W'(NBYTES)) ? csum_q : frame_q[FRAME_W-1 -: 8];
`else
  assign tx_byte_c = frame_q[FRAME_W-1 -: 8];
`endif

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (pop_c) begin
          case (uart.r_data)
            CMD_RUN:  state_d = S_RUN;
            CMD_STEP: state_d = S_STEP;
            CMD_DUMP: state_d = S_SNAP;
            default:  state_d = S_IDLE;
          endcase
        end
      end
      S_RUN:  if (pop_c && uart.r_data == CMD_HALT) state_d = S_IDLE;
      S_STEP: state_d = S_SNAP;
      S_SNAP: state_d = S_SEND;
      S_SEND: if (push_c && last_c) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode; held quiet while reset is asserted so an interrupted frame stops immediately
  always_comb begin
    enable      = 1'b0;
    busy        = 1'b0;
    uart.rd     = 1'b0;
    uart.wr     = 1'b0;
    uart.w_data = '0;
    if (!reset) begin
      enable      = (state_q == S_RUN) || (state_q == S_STEP);
      busy        = (state_q == S_STEP) || (state_q == S_SNAP) || (state_q == S_SEND);
      uart.rd     = pop_c;
      uart.wr     = push_c;
      uart.w_data = tx_byte_c;
    end
  end

  // Frame is a shift register: MSB byte always presented, shifted out one byte per push
  always_comb begin
    frame_d = frame_q;
    idx_d   = idx_q;
    if (state_q == S_SNAP) begin
      frame_d = FRAME_W'({PC_plus_1, debug_signal});
      idx_d   = '0;
    end else if (push_c) begin
      frame_d = {frame_q[FRAME_W-9:0], 8'h00};
      idx_d   = idx_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      frame_q <= '0;
      idx_q   <= '0;
    end else begin
      frame_q <= frame_d;
      idx_q   <= idx_d;
    end
  end
endmodule

// File: tb/tb_debug_link_unit.sv
// Scoreboard bench for debug_link_unit: stimulus queues expected bytes/control, monitor compares.
module tb_debug_link_unit;
  localparam int unsigned DBG_W  = 322;
  localparam int unsigned PC_W   = 10;
  localparam int unsigned NBYTES = 42;
`ifdef DEBUG_LINK_CHECKSUM_EN
  localparam int FR = NBYTES + 1;
`else
  localparam int FR = NBYTES;
`endif

  typedef struct packed {
    logic en;
    logic bsy;
    logic rd;
    logic wr;
  } ctl_t;

  logic              clock = 1'b0;
  logic              reset;
  logic [DBG_W-1:0]  dbg_stim;
  logic [DBG_W-1:0]  debug_signal;
  logic [PC_W-1:0]   pc;
  logic              enable, busy;
  logic              core_mode, core_clr;
  logic [7:0]        core_cnt;

  logic [7:0] rxq[$];
  logic [7:0] expq[$];
  ctl_t       ctlq[$];
  int         n_vec = 0;
  int         n_err = 0;
  bit         done = 1'b0;

  debug_link_unit_if u();

  debug_link_unit #(.DBG_W(DBG_W), .PC_W(PC_W), .NBYTES(NBYTES)) dut (
    .clock        (clock),
    .reset        (reset),
    .debug_signal (debug_signal),
    .PC_plus_1    (pc),
    .enable       (enable),
    .busy         (busy),
    .uart         (u)
  );

  always #5 clock = ~clock;

  // Tiny core model: a counter that advances on enable, exposed on the debug bus
  always @(posedge clock) begin
    if (core_clr) core_cnt <= 8'h00;
    else if (enable) core_cnt <= core_cnt + 8'h01;
  end
  assign debug_signal = core_mode ? DBG_W'(core_cnt) : dbg_stim;

  task automatic check8(input string nm, input logic [7:0] act, input logic [7:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s at %0t: got %02h expected %02h", nm, $time, act, expv);
    end
  endtask

  // Monitor: per-cycle control expectations and TX byte scoreboard
  always @(negedge clock) begin : mon
    ctl_t e;
    if (ctlq.size() > 0) begin
      e = ctlq.pop_front();
      check8("enable", 8'(enable), 8'(e.en));
      check8("busy",   8'(busy),   8'(e.bsy));
      check8("rd",     8'(u.rd),   8'(e.rd));
      check8("wr",     8'(u.wr),   8'(e.wr));
    end
    if (u.wr === 1'b1) begin
      if (expq.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_wr at %0t: got byte %02h expected no write", $time, u.w_data);
      end else begin
        check8("w_data", u.w_data, expq.pop_front());
      end
    end
    if (done) begin
      check8("bytes_left", 8'(expq.size()), 8'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no end of test, expected finish");
    $fatal(1, "timeout");
  end

  function automatic ctl_t x(input logic en, input logic bsy, input logic rd, input logic wr);
    ctl_t r;
    r.en = en; r.bsy = bsy; r.rd = rd; r.wr = wr;
    return r;
  endfunction

  task automatic refresh_rx();
    u.rx_empty = (rxq.size() == 0);
    u.r_data   = (rxq.size() > 0) ? rxq[0] : 8'h00;
  endtask

  task automatic push_rx(input logic [7:0] b);
    rxq.push_back(b);
    refresh_rx();
  endtask

  // One clock cycle: queue expectation, observe, then model the RX FIFO pop
  task automatic cyc(input ctl_t e);
    logic popped;
    ctlq.push_back(e);
    @(negedge clock);
    popped = u.rd;
    @(posedge clock);
    #1;
    if (popped && rxq.size() > 0) void'(rxq.pop_front());
    refresh_rx();
  endtask

  task automatic send_frame(input logic [335:0] f, input int stall_at, input int rst_at, input logic pending);
    logic [7:0] b[NBYTES+1];
    logic [7:0] cs;
    cs = 8'h00;
    for (int j = 0; j < NBYTES; j++) begin
      b[j] = f[335 - 8*j -: 8];
      cs   = cs ^ b[j];
    end
    b[NBYTES] = cs;
    for (int j = 0; j < FR; j++) begin
      if (j == rst_at) begin
        reset = 1'b1;
        cyc(x(0, 0, 0, 0));
        reset = 1'b0;
        cyc(x(0, 0, 0, 0));
        return;
      end
      if (j == stall_at) begin
        u.tx_full = 1'b1;
        repeat (5) cyc(x(0, 1, 0, 0));
        u.tx_full = 1'b0;
      end
      expq.push_back(b[j]);
      cyc(x(0, 1, 0, 1));
    end
    cyc(x(0, 0, pending, 0));
  endtask

  // 'd' command; inputs differ outside the snapshot cycle so capture timing is exercised
  task automatic send_dump(input logic [DBG_W-1:0] d, input logic [PC_W-1:0] p,
                           input int stall_at, input int rst_at);
    dbg_stim = ~d; pc = ~p;
    push_rx(8'h64);
    cyc(x(0, 0, 1, 0));
    dbg_stim = d; pc = p;
    cyc(x(0, 1, 0, 0));
    dbg_stim = ~d; pc = ~p;
    send_frame({4'b0, p, d}, stall_at, rst_at, 1'b0);
  endtask

  initial begin
    reset     = 1'b1;
    u.tx_full = 1'b0;
    dbg_stim  = '0;
    pc        = '0;
    core_mode = 1'b0;
    core_clr  = 1'b1;
    push_rx(8'h63);
    repeat (3) cyc(x(0, 0, 0, 0));
    reset    = 1'b0;
    core_clr = 1'b0;

    // run, a stray byte while running, then halt
    cyc(x(0, 0, 1, 0));
    for (int i = 0; i < 20; i++) begin
      if (i == 9) push_rx(8'h41);
      cyc(x(1, 0, (i == 9), 0));
    end
    push_rx(8'h68);
    cyc(x(1, 0, 1, 0));
    cyc(x(0, 0, 0, 0));

    send_dump(DBG_W'(1), 10'h3FF, -1, -1);

    // unknown byte in IDLE is discarded
    push_rx(8'h41);
    cyc(x(0, 0, 1, 0));
    cyc(x(0, 0, 0, 0));

    send_dump({2'b10, {40{8'hA5}}}, 10'h2C3, 10, -1);
    send_dump({2'b01, {40{8'h3C}}}, 10'h11F, -1, 20);
    send_dump({2'b01, {40{8'h3C}}}, 10'h11F, -1, -1);

    // single step with a queued halt that must wait until the frame is done
    core_clr = 1'b1;
    cyc(x(0, 0, 0, 0));
    core_clr  = 1'b0;
    core_mode = 1'b1;
    pc        = 10'h155;
    push_rx(8'h73);
    push_rx(8'h68);
    cyc(x(0, 0, 1, 0));
    cyc(x(1, 1, 0, 0));
    cyc(x(0, 1, 0, 0));
    send_frame({4'b0, 10'h155, DBG_W'(8'd1)}, -1, -1, 1'b1);
    cyc(x(0, 0, 0, 0));

    done = 1'b1;
    repeat (3) @(posedge clock);
  end
endmodule
